// File: rtl/rf_dump_reader.sv
// Read-side dump master for register_file: walks [first_reg..last_reg] two
// registers per fetch and streams each value out tagged with its index.
module rf_dump_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    output logic [ADDR_WIDTH-1:0] rA_address,
    output logic [ADDR_WIDTH-1:0] rB_address,
    input  logic [0:DATA_WIDTH-1] rA_data,
    input  logic [0:DATA_WIDTH-1] rB_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:DATA_WIDTH-1] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           end_q, end_d;
    logic [0:DATA_WIDTH-1]   ent_data_q [2];
    logic [0:DATA_WIDTH-1]   ent_data_d [2];
    logic [1:0]              ent_vld_q, ent_vld_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;

    logic [PW-1:0]           ptr_p1, ptr_p2;
    logic                    present_e1;
    logic                    handshake;
    logic                    drain_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            end_q     <= '0;
            ent_vld_q <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            for (int i = 0; i < 2; i++) ent_data_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            end_q     <= end_d;
            ent_vld_q <= ent_vld_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            for (int i = 0; i < 2; i++) ent_data_q[i] <= ent_data_d[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        end_d         = end_q;
        ent_vld_d     = ent_vld_q;
        addr_a_d      = addr_a_q;
        addr_b_d      = addr_b_q;
        ent_data_d[0] = ent_data_q[0];
        ent_data_d[1] = ent_data_q[1];

        ptr_p1     = ptr_q + PW'(1);
        ptr_p2     = ptr_q + PW'(2);
        present_e1 = !ent_vld_q[0] && ent_vld_q[1];
        out_valid  = (state_q == DRAIN) && (|ent_vld_q);
        handshake  = out_valid && out_ready;
        drain_last = handshake && (present_e1 || !ent_vld_q[1]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = {1'b0, first_reg};
                    end_d   = {1'b0, last_reg};
                    state_d = FETCH;
                end
            end
            FETCH: begin
                addr_a_d = ptr_q[ADDR_WIDTH-1:0];
                addr_b_d = ptr_p1[ADDR_WIDTH-1:0];
                // An inverted range is only detected here, so an empty dump
                // still spends one busy cycle before DONE.
                if (ptr_q > end_q) begin
                    state_d = DONE;
                end else begin
                    ent_data_d[0] = rA_data;
                    ent_data_d[1] = rB_data;
                    ent_vld_d     = {(ptr_p1 <= end_q), 1'b1};
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    if (present_e1) ent_vld_d[1] = 1'b0;
                    else            ent_vld_d[0] = 1'b0;
                end
                if (drain_last) begin
                    ptr_d   = ptr_p2;
                    state_d = (ptr_p2 <= end_q) ? FETCH : DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rA_address = (state_q == FETCH) ? ptr_q[ADDR_WIDTH-1:0]  : addr_a_q;
    assign rB_address = (state_q == FETCH) ? ptr_p1[ADDR_WIDTH-1:0] : addr_b_q;
    assign out_data   = present_e1 ? ent_data_q[1] : ent_data_q[0];
    assign out_index  = present_e1 ? ptr_p1[ADDR_WIDTH-1:0] : ptr_q[ADDR_WIDTH-1:0];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: register-file model, scoreboard of expected
// (index, data) words, and cycle-exact checks on the reference dump.
module tb_rf_dump_reader;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_reg, last_reg;
    logic [AW-1:0] rA_address, rB_address;
    logic [0:DW-1] rA_data, rB_data;
    logic          out_valid, out_ready;
    logic [0:DW-1] out_data;
    logic [AW-1:0] out_index;
    logic          busy, done;

    logic [0:DW-1] regs [32];

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [0:DW-1] data;
    } word_t;

    word_t sb[$];

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;

    logic          stall_q = 1'b0;
    logic [0:DW-1] stall_data;
    logic [AW-1:0] stall_idx;

    always #5 clk = ~clk;

    assign rA_data = regs[rA_address];
    assign rB_data = regs[rB_address];

    rf_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_reg  (first_reg),
        .last_reg   (last_reg),
        .rA_address (rA_address),
        .rB_address (rB_address),
        .rA_data    (rA_data),
        .rB_data    (rB_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Monitor: handshakes are judged at the falling edge, ahead of the
    // rising edge that completes them.
    always @(negedge clk) begin
        if (!reset) begin
            word_t w;
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
            if (stall_q) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_index", 64'(out_index), 64'(stall_idx));
                check("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'(out_index), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    check("hs_index", 64'(out_index), 64'(w.idx));
                    check("hs_data", out_data, w.data);
                end
            end
            stall_q    <= out_valid && !out_ready;
            stall_data <= out_data;
            stall_idx  <= out_index;
        end else begin
            stall_q <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) sb.push_back({AW'(i), regs[i]});
    endtask

    task automatic do_start(input int f, input int l, input bit expect_words);
        first_reg = AW'(f);
        last_reg  = AW'(l);
        start     = 1'b1;
        if (expect_words) push_range(f, l);
        hs_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {32'hA5A5_0000, 32'(i)};
        regs[1]  = 64'h200200000000FA50;
        regs[2]  = 64'h0002000000006840;
        regs[3]  = 64'h00020000000ABCDE;
        regs[31] = 64'h00020000000FFFFF;

        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        first_reg = '0; last_reg = '0;
        repeat (3) step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_rA", 64'(rA_address), 64'd0);
        check("rst_rB", 64'(rB_address), 64'd0);
        reset = 1'b0;
        step();

        // Reference dump 1..3, cycle exact
        do_start(1, 3, 1'b1);
        step(); start = 1'b0;
        check("k1_busy", 64'(busy), 64'd1);
        check("k1_valid", 64'(out_valid), 64'd0);
        step();
        check("k2_valid", 64'(out_valid), 64'd1);
        check("k2_index", 64'(out_index), 64'd1);
        check("k2_data", out_data, 64'h200200000000FA50);
        step();
        check("k3_index", 64'(out_index), 64'd2);
        check("k3_data", out_data, 64'h0002000000006840);
        step();
        check("k4_valid", 64'(out_valid), 64'd0);
        step();
        check("k5_valid", 64'(out_valid), 64'd1);
        check("k5_index", 64'(out_index), 64'd3);
        check("k5_data", out_data, 64'h00020000000ABCDE);
        step();
        check("k6_valid", 64'(out_valid), 64'd0);
        check("k6_done", 64'(done), 64'd1);
        step();
        check("k7_busy", 64'(busy), 64'd0);
        check("k7_done", 64'(done), 64'd0);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);
        step();

        // Same dump with back-pressure during k+2..k+5
        out_ready = 1'b0;
        do_start(1, 3, 1'b1);
        step(); start = 1'b0;
        repeat (4) step();
        check("bp_hold_index", 64'(out_index), 64'd1);
        out_ready = 1'b1;
        wait_done();
        check("bp_hs_cnt", 64'(hs_cnt), 64'd3);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Top of the register space: no wrap to r0
        do_start(30, 31, 1'b1);
        step(); start = 1'b0;
        wait_done();
        check("top_hs_cnt", 64'(hs_cnt), 64'd2);
        check("top_sb_empty", 64'(sb.size()), 64'd0);

        // Inverted range: empty dump
        do_start(5, 4, 1'b0);
        step(); start = 1'b0;
        check("empty_k1_busy", 64'(busy), 64'd1);
        check("empty_k1_done", 64'(done), 64'd0);
        step();
        check("empty_k2_done", 64'(done), 64'd1);
        check("empty_k2_busy", 64'(busy), 64'd1);
        step();
        check("empty_k3_busy", 64'(busy), 64'd0);
        check("empty_valid_cnt", 64'(valid_cnt), 64'd0);

        // Start while busy is ignored
        do_start(1, 3, 1'b1);
        step(); start = 1'b0;
        step();
        first_reg = '0; last_reg = '0; start = 1'b1;
        step(); start = 1'b0;
        wait_done();
        check("busy_start_hs_cnt", 64'(hs_cnt), 64'd3);
        check("busy_start_sb_empty", 64'(sb.size()), 64'd0);
        repeat (3) step();
        check("busy_start_idle", 64'(busy), 64'd0);

        // Reset in the cycle after the first handshake
        do_start(1, 3, 1'b1);
        step(); start = 1'b0;
        step();
        step();
        reset = 1'b1;
        begin
            int dc;
            dc = done_cnt;
            step();
            check("rst_mid_valid", 64'(out_valid), 64'd0);
            check("rst_mid_busy", 64'(busy), 64'd0);
            check("rst_mid_done", 64'(done), 64'd0);
            reset = 1'b0;
            sb.delete();
            repeat (3) step();
            check("rst_mid_no_done", 64'(done_cnt), 64'(dc));
        end

        // Fresh single-register dump
        do_start(1, 1, 1'b1);
        step(); start = 1'b0;
        wait_done();
        check("single_hs_cnt", 64'(hs_cnt), 64'd1);
        check("single_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
